hwce_sop_acc: RTL

//   Parametrised sum-of-products engine of the HWCE. Takes NPX pixels per beat and one shared weight,

---
 rtl/hwce_sop_acc_if.sv | 25 ++
 rtl/hwce_sop_acc.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/hwce_sop_acc_if.sv
// Beat/result handshake bundle for the HWCE sum-of-products engine.
// master = feeder/consumer side, slave = hwce_sop_acc.
interface hwce_sop_acc_if #(
    parameter int CONV_WIDTH = 16,
    parameter int NPX        = 4,
    parameter int SUM_WIDTH  = 48
);
    logic                      x_in_valid;
    logic                      x_in_ready;
    logic [NPX*CONV_WIDTH-1:0] x_in;
    logic [CONV_WIDTH-1:0]     w_in;
    logic                      y_out_valid;
    logic                      y_out_ready;
    logic [NPX*SUM_WIDTH-1:0]  y_out;

    modport master (
        output x_in_valid, x_in, w_in, y_out_ready,
        input  x_in_ready, y_out_valid, y_out
    );

    modport slave (
        input  x_in_valid, x_in, w_in, y_out_ready,
        output x_in_ready, y_out_valid, y_out
    );
endinterface

// File: rtl/hwce_sop_acc.sv
// HWCE sum-of-products engine: NPX lanes x shared weight, accumulated over an fs_w x fs_h window.
// Optional output round/saturate stage enabled by defining HWCE_SOP_ROUND_SAT_EN (adds port qf).
module hwce_sop_acc #(
    parameter int CONV_WIDTH  = 16,
    parameter int NPX         = 4,
    parameter int SUM_WIDTH   = 48,
    parameter int PIPE_STAGES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] fs_w,
    input  logic [7:0] fs_h,
    input  logic       precision8,
`ifdef HWCE_SOP_ROUND_SAT_EN
    input  logic [5:0] qf,
`endif
    output logic       busy,
    hwce_sop_acc_if.slave bus
);

    localparam int HC = CONV_WIDTH / 2;
    localparam int HS = SUM_WIDTH / 2;

    logic [15:0] tap_cnt;
    logic [15:0] win_len_q;
    logic [15:0] win_len;
    logic [7:0]  fw_eff;
    logic [7:0]  fh_eff;
    logic        p8_q;
    logic        p8_in;
    logic        last_in;
    logic        stall;
    logic        accept;

    logic [PIPE_STAGES-1:0] pv;
    logic [PIPE_STAGES-1:0] pl;
    logic [PIPE_STAGES-1:0] pp8;
    logic [SUM_WIDTH-1:0]   pprod [PIPE_STAGES][NPX];

    logic        exit_v;
    logic        exit_last;
    logic        exit_p8;

    logic [CONV_WIDTH-1:0]          x_lane    [NPX];
    logic signed [2*CONV_WIDTH-1:0] prod_full [NPX];
    logic signed [CONV_WIDTH-1:0]   prod_hi   [NPX];
    logic signed [CONV_WIDTH-1:0]   prod_lo   [NPX];
    logic [SUM_WIDTH-1:0]           prod_in   [NPX];
    logic [SUM_WIDTH-1:0]           acc       [NPX];
    logic [SUM_WIDTH-1:0]           sum       [NPX];
    logic [SUM_WIDTH-1:0]           y_load    [NPX];

`ifdef HWCE_SOP_ROUND_SAT_EN
    function automatic logic [SUM_WIDTH-1:0] rs_full(input logic [SUM_WIDTH-1:0] v, input logic [5:0] q);
        logic signed [SUM_WIDTH:0] t;
        logic signed [SUM_WIDTH:0] smax;
        logic signed [SUM_WIDTH:0] smin;
        smax = '0;
        smax[CONV_WIDTH-2:0] = '1;
        smin = ~smax;
        t = $signed({v[SUM_WIDTH-1], v});
        if (q != 6'd0) t = t + ((SUM_WIDTH+1)'(1) << (q - 6'd1));
        t = t >>> q;
        if (t > smax) t = smax;
        else if (t < smin) t = smin;
        return t[SUM_WIDTH-1:0];
    endfunction

    function automatic logic [HS-1:0] rs_half(input logic [HS-1:0] v, input logic [5:0] q);
        logic signed [HS:0] t;
        logic signed [HS:0] smax;
        logic signed [HS:0] smin;
        smax = '0;
        smax[HC-2:0] = '1;
        smin = ~smax;
        t = $signed({v[HS-1], v});
        if (q != 6'd0) t = t + ((HS+1)'(1) << (q - 6'd1));
        t = t >>> q;
        if (t > smax) t = smax;
        else if (t < smin) t = smin;
        return t[HS-1:0];
    endfunction
`endif

    // Window geometry and precision come from the live inputs on the first beat, then from the latch.
    always_comb begin
        fw_eff  = (fs_w == 8'd0) ? 8'd1 : fs_w;
        fh_eff  = (fs_h == 8'd0) ? 8'd1 : fs_h;
        win_len = (tap_cnt == 16'd0) ? (16'(fw_eff) * 16'(fh_eff)) : win_len_q;
        p8_in   = (tap_cnt == 16'd0) ? precision8 : p8_q;
        last_in = (tap_cnt == win_len - 16'd1);
    end

    assign exit_v    = pv[PIPE_STAGES-1];
    assign exit_last = pl[PIPE_STAGES-1];
    assign exit_p8   = pp8[PIPE_STAGES-1];

    assign stall          = bus.y_out_valid & ~bus.y_out_ready & exit_v & exit_last;
    assign bus.x_in_ready = ~rst & enable & ~clear & ~stall;
    assign accept         = bus.x_in_valid & bus.x_in_ready;
    assign busy           = (tap_cnt != 16'd0) | (|pv);

    always_comb begin
        for (int n = 0; n < NPX; n++) begin
            x_lane[n]    = bus.x_in[n*CONV_WIDTH +: CONV_WIDTH];
            prod_full[n] = (2*CONV_WIDTH)'($signed(x_lane[n])) * (2*CONV_WIDTH)'($signed(bus.w_in));
            prod_hi[n]   = CONV_WIDTH'($signed(x_lane[n][CONV_WIDTH-1:HC])) * CONV_WIDTH'($signed(bus.w_in[HC-1:0]));
            prod_lo[n]   = CONV_WIDTH'($signed(x_lane[n][HC-1:0])) * CONV_WIDTH'($signed(bus.w_in[HC-1:0]));
            prod_in[n]   = p8_in ? {HS'(prod_hi[n]), HS'(prod_lo[n])} : SUM_WIDTH'(prod_full[n]);
        end
    end

    // In packed mode the carry between halves is dropped so each half wraps on its own.
    always_comb begin
        for (int n = 0; n < NPX; n++) begin
            if (exit_p8)
                sum[n] = {acc[n][SUM_WIDTH-1:HS] + pprod[PIPE_STAGES-1][n][SUM_WIDTH-1:HS],
                          acc[n][HS-1:0] + pprod[PIPE_STAGES-1][n][HS-1:0]};
            else
                sum[n] = acc[n] + pprod[PIPE_STAGES-1][n];
`ifdef HWCE_SOP_ROUND_SAT_EN
            if (exit_p8)
                y_load[n] = {rs_half(sum[n][SUM_WIDTH-1:HS], qf), rs_half(sum[n][HS-1:0], qf)};
            else
                y_load[n] = rs_full(sum[n], qf);
`else
            y_load[n] = sum[n];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_cnt         <= '0;
            win_len_q       <= '0;
            p8_q            <= 1'b0;
            pv              <= '0;
            pl              <= '0;
            pp8             <= '0;
            bus.y_out_valid <= 1'b0;
            bus.y_out       <= '0;
            for (int n = 0; n < NPX; n++) begin
                acc[n] <= '0;
                for (int s = 0; s < PIPE_STAGES; s++) pprod[s][n] <= '0;
            end
        end else if (clear) begin
            tap_cnt         <= '0;
            win_len_q       <= '0;
            p8_q            <= 1'b0;
            pv              <= '0;
            pl              <= '0;
            pp8             <= '0;
            bus.y_out_valid <= 1'b0;
            for (int n = 0; n < NPX; n++) begin
                acc[n] <= '0;
                for (int s = 0; s < PIPE_STAGES; s++) pprod[s][n] <= '0;
            end
        end else if (enable) begin
            if (bus.y_out_valid && bus.y_out_ready) bus.y_out_valid <= 1'b0;
            if (!stall) begin
                for (int s = 1; s < PIPE_STAGES; s++) begin
                    pv[s]    <= pv[s-1];
                    pl[s]    <= pl[s-1];
                    pp8[s]   <= pp8[s-1];
                    pprod[s] <= pprod[s-1];
                end
                pv[0]    <= accept;
                pl[0]    <= accept & last_in;
                pp8[0]   <= p8_in;
                pprod[0] <= prod_in;
                if (accept) begin
                    if (tap_cnt == 16'd0) begin
                        win_len_q <= win_len;
                        p8_q      <= precision8;
                    end
                    tap_cnt <= last_in ? 16'd0 : tap_cnt + 16'd1;
                end
                if (exit_v) begin
                    if (exit_last) begin
                        bus.y_out_valid <= 1'b1;
                        for (int n = 0; n < NPX; n++) begin
                            bus.y_out[n*SUM_WIDTH +: SUM_WIDTH] <= y_load[n];
                            acc[n] <= '0;
                        end
                    end else begin
                        for (int n = 0; n < NPX; n++) acc[n] <= sum[n];
                    end
                end
            end
        end
    end

endmodule
